mp3_ui_ctrl: RTL and testbench



---
 rtl/mp3_ui_ctrl_if.sv | 34 +++
 rtl/mp3_ui_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mp3_ui_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mp3_ui_ctrl_if.sv
// Front-panel control bus: raw button levels and vsync in, frame-stable
// display values and highlight/status flags out.
interface mp3_ui_ctrl_if;
  logic        i_next;
  logic        i_pre;
  logic        i_vol_plus;
  logic        i_vol_dec;
  logic        i_vs;
  logic [3:0]  o_track;
  logic [3:0]  o_vol;
  logic [14:0] o_progress;
  logic        o_hl_next;
  logic        o_hl_pre;
  logic        o_hl_volp;
  logic        o_hl_vold;
  logic        o_track_chg;
  logic        o_busy;

  // Panel / stimulus side: drives buttons and vsync, observes the display values.
  modport master (
    output i_next, i_pre, i_vol_plus, i_vol_dec, i_vs,
    input  o_track, o_vol, o_progress,
    input  o_hl_next, o_hl_pre, o_hl_volp, o_hl_vold,
    input  o_track_chg, o_busy
  );

  // Controller side.
  modport slave (
    input  i_next, i_pre, i_vol_plus, i_vol_dec, i_vs,
    output o_track, o_vol, o_progress,
    output o_hl_next, o_hl_pre, o_hl_volp, o_hl_vold,
    output o_track_chg, o_busy
  );
endinterface

// File: rtl/mp3_ui_ctrl.sv
// MP3 front-panel control sequencer: button edge detection with fixed
// priority, track/volume/progress state, timed highlights, and display
// values double-buffered on the vsync rising edge.
module mp3_ui_ctrl #(
  parameter int NUM_TRACKS  = 4,
  parameter int VOL_MAX     = 15,
  parameter int VOL_INIT    = 8,
  parameter int HOLD_CYCLES = 50,
  parameter int TICK_CYCLES = 1000000,
  parameter int PROG_MAX    = 32767
) (
  input  logic            clk,
  input  logic            rst,
  mp3_ui_ctrl_if.slave    bus
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_CYCLES - 1);
  localparam logic [14:0]   PROG_LAST  = 15'(PROG_MAX);
  localparam logic [3:0]    TRACK_LAST = 4'(NUM_TRACKS - 1);
  localparam logic [3:0]    VOL_TOP    = 4'(VOL_MAX);
  localparam logic [3:0]    VOL_RST    = 4'(VOL_INIT);

  typedef enum logic [1:0] {IDLE, HOLD, WAIT_REL} state_t;

  // Button vectors are ordered {next, pre, vol_plus, vol_dec}; bit 3 wins.
  state_t        state_q, state_d;
  logic [3:0]    btn_hist_q, btn_hist_d;
  logic          vs_hist_q, vs_hist_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [TW-1:0] presc_q, presc_d;
  logic [3:0]    track_q, track_d;
  logic [3:0]    vol_q, vol_d;
  logic [14:0]   prog_q, prog_d;
  logic [3:0]    hl_q, hl_d;
  logic          track_chg_q, track_chg_d;
  logic          busy_q, busy_d;
  logic [3:0]    out_track_q, out_track_d;
  logic [3:0]    out_vol_q, out_vol_d;
  logic [14:0]   out_prog_q, out_prog_d;

  logic [3:0] btn;
  logic [3:0] rise;

  assign btn  = {bus.i_next, bus.i_pre, bus.i_vol_plus, bus.i_vol_dec};
  assign rise = btn & ~btn_hist_q;

  // Next-state logic: FSM, value updates, progress timing and frame buffer.
  always_comb begin
    state_d     = state_q;
    btn_hist_d  = btn;
    vs_hist_d   = bus.i_vs;
    hold_cnt_d  = hold_cnt_q;
    presc_d     = presc_q;
    track_d     = track_q;
    vol_d       = vol_q;
    prog_d      = prog_q;
    hl_d        = hl_q;
    track_chg_d = 1'b0;
    out_track_d = out_track_q;
    out_vol_d   = out_vol_q;
    out_prog_d  = out_prog_q;

    case (state_q)
      IDLE: begin
        if (|rise) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
          if (rise[3]) begin
            track_d     = (track_q == TRACK_LAST) ? 4'd0 : track_q + 4'd1;
            track_chg_d = 1'b1;
            hl_d        = 4'b1000;
          end else if (rise[2]) begin
            track_d     = (track_q == 4'd0) ? TRACK_LAST : track_q - 4'd1;
            track_chg_d = 1'b1;
            hl_d        = 4'b0100;
          end else if (rise[1]) begin
            // Saturated presses still highlight and still enter HOLD.
            vol_d = (vol_q == VOL_TOP) ? VOL_TOP : vol_q + 4'd1;
            hl_d  = 4'b0010;
          end else begin
            vol_d = (vol_q == 4'd0) ? 4'd0 : vol_q - 4'd1;
            hl_d  = 4'b0001;
          end
        end
      end
      HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          hl_d    = 4'b0000;
          state_d = (|btn) ? WAIT_REL : IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      WAIT_REL: begin
        if (~|btn) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);

    // A track change restarts playback timing and overrides a same-cycle tick.
    if (track_chg_d) begin
      presc_d = '0;
      prog_d  = '0;
    end else if (presc_q == TICK_LAST) begin
      presc_d = '0;
      if (prog_q != PROG_LAST) prog_d = prog_q + 15'd1;
    end else begin
      presc_d = presc_q + TW'(1);
    end

    // Display copies take the values as they stood before this edge.
    if (bus.i_vs && !vs_hist_q) begin
      out_track_d = track_q;
      out_vol_d   = vol_q;
      out_prog_d  = prog_q;
    end
  end

  // All state and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      btn_hist_q  <= '0;
      vs_hist_q   <= 1'b0;
      hold_cnt_q  <= '0;
      presc_q     <= '0;
      track_q     <= '0;
      vol_q       <= VOL_RST;
      prog_q      <= '0;
      hl_q        <= '0;
      track_chg_q <= 1'b0;
      busy_q      <= 1'b0;
      out_track_q <= '0;
      out_vol_q   <= VOL_RST;
      out_prog_q  <= '0;
    end else begin
      state_q     <= state_d;
      btn_hist_q  <= btn_hist_d;
      vs_hist_q   <= vs_hist_d;
      hold_cnt_q  <= hold_cnt_d;
      presc_q     <= presc_d;
      track_q     <= track_d;
      vol_q       <= vol_d;
      prog_q      <= prog_d;
      hl_q        <= hl_d;
      track_chg_q <= track_chg_d;
      busy_q      <= busy_d;
      out_track_q <= out_track_d;
      out_vol_q   <= out_vol_d;
      out_prog_q  <= out_prog_d;
    end
  end

  assign bus.o_track     = out_track_q;
  assign bus.o_vol       = out_vol_q;
  assign bus.o_progress  = out_prog_q;
  assign bus.o_hl_next   = hl_q[3];
  assign bus.o_hl_pre    = hl_q[2];
  assign bus.o_hl_volp   = hl_q[1];
  assign bus.o_hl_vold   = hl_q[0];
  assign bus.o_track_chg = track_chg_q;
  assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_mp3_ui_ctrl.sv
// Self-checking bench for mp3_ui_ctrl: frame outputs go through a
// scoreboard queue checked by a monitor on each vsync rise; flag timing is
// checked inline by the stimulus.
module tb_mp3_ui_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mp3_ui_ctrl_if bus_if();

  mp3_ui_ctrl #(
    .NUM_TRACKS(4), .VOL_MAX(15), .VOL_INIT(8),
    .HOLD_CYCLES(4), .TICK_CYCLES(10), .PROG_MAX(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.slave)
  );

  typedef struct {
    int track;
    int vol;
    int prog;
    bit prog_chk;
    int id;
  } frame_t;

  frame_t sb[$];
  frame_t mon_e;
  int checks    = 0;
  int errors    = 0;
  int chg_count = 0;
  int fid       = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int hl_vec();
    return {28'd0, bus_if.o_hl_next, bus_if.o_hl_pre, bus_if.o_hl_volp, bus_if.o_hl_vold};
  endfunction

  // Monitor: track vsync rises like the panel sees them and compare the
  // frame-stable outputs just after each one.
  logic vs_h, frame_due;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_h      <= 1'b0;
      frame_due <= 1'b0;
    end else begin
      frame_due <= bus_if.i_vs && !vs_h;
      vs_h      <= bus_if.i_vs;
    end
  end

  always @(negedge clk) begin
    if (bus_if.o_track_chg === 1'b1) chg_count++;
    if (frame_due) begin
      if (sb.size() == 0) begin
        chk("frame_unexpected", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("frame_track", int'(bus_if.o_track), mon_e.track);
        chk("frame_vol", int'(bus_if.o_vol), mon_e.vol);
        if (mon_e.prog_chk) chk("frame_prog", int'(bus_if.o_progress), mon_e.prog);
        $display("frame %0d: track %0d vol %0d progress %0d", mon_e.id,
                 bus_if.o_track, bus_if.o_vol, bus_if.o_progress);
      end
    end
  end

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: bus_if.i_next     = v;
      1: bus_if.i_pre      = v;
      2: bus_if.i_vol_plus = v;
      default: bus_if.i_vol_dec = v;
    endcase
  endtask

  // Queue expected frame values, then raise vsync for one cycle.
  task automatic frame(input int t, input int v, input int p, input bit pc);
    frame_t e;
    e.track = t; e.vol = v; e.prog = p; e.prog_chk = pc; e.id = fid;
    fid++;
    sb.push_back(e);
    bus_if.i_vs = 1'b1;
    @(negedge clk);
    bus_if.i_vs = 1'b0;
    @(negedge clk);
  endtask

  // One-cycle button press from IDLE; highlight must last exactly 4 cycles.
  task automatic pulse(input int b, input int exp_hl, input int exp_chg);
    set_btn(b, 1'b1);
    @(negedge clk);
    chk("hl_on", hl_vec(), exp_hl);
    chk("chg_on", int'(bus_if.o_track_chg), exp_chg);
    chk("busy_on", int'(bus_if.o_busy), 1);
    set_btn(b, 1'b0);
    @(negedge clk);
    chk("chg_off", int'(bus_if.o_track_chg), 0);
    repeat (2) @(negedge clk);
    chk("hl_last", hl_vec(), exp_hl);
    @(negedge clk);
    chk("hl_off", hl_vec(), 0);
    chk("busy_off", int'(bus_if.o_busy), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_track"}, int'(bus_if.o_track), 0);
    chk({tag, "_vol"}, int'(bus_if.o_vol), 8);
    chk({tag, "_prog"}, int'(bus_if.o_progress), 0);
    chk({tag, "_hl"}, hl_vec(), 0);
    chk({tag, "_chg"}, int'(bus_if.o_track_chg), 0);
    chk({tag, "_busy"}, int'(bus_if.o_busy), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hl_cnt;
    bus_if.i_next = 0; bus_if.i_pre = 0; bus_if.i_vol_plus = 0;
    bus_if.i_vol_dec = 0; bus_if.i_vs = 0;
    #1 rst = 1'b1;
    #1 check_reset_vals("rst0");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Held next: highlight 4 cycles, busy until release, display waits for vsync.
    bus_if.i_next = 1'b1;
    hl_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) chk("t1_chg", int'(bus_if.o_track_chg), 1);
      hl_cnt += int'(bus_if.o_hl_next);
    end
    chk("t1_hl_cycles", hl_cnt, 4);
    chk("t1_busy_wait", int'(bus_if.o_busy), 1);
    chk("t1_track_unbuf", int'(bus_if.o_track), 0);
    bus_if.i_next = 1'b0;
    @(negedge clk);
    chk("t1_busy_rel", int'(bus_if.o_busy), 0);
    frame(1, 8, 0, 0);

    // Track wrap downwards then a full forward lap.
    pulse(1, 4'b0100, 1); frame(0, 8, 0, 0);
    pulse(1, 4'b0100, 1); frame(3, 8, 0, 0);
    for (int i = 0; i < 4; i++) begin
      pulse(0, 4'b1000, 1);
      frame(i, 8, 0, 0);
    end

    // Volume saturation at both ends.
    for (int i = 1; i <= 9; i++) begin
      pulse(2, 4'b0010, 0);
      if (i == 6 || i == 7 || i == 9) frame(3, (8 + i > 15) ? 15 : 8 + i, 0, 0);
    end
    for (int i = 1; i <= 20; i++) begin
      pulse(3, 4'b0001, 0);
      if (i == 14 || i == 15 || i == 20) frame(3, (15 - i < 0) ? 0 : 15 - i, 0, 0);
    end

    // Simultaneous rises: next wins; a rise during HOLD is dropped.
    bus_if.i_next = 1'b1; bus_if.i_vol_dec = 1'b1;
    @(negedge clk);
    chk("t4_hl_prio", hl_vec(), 4'b1000);
    bus_if.i_next = 1'b0; bus_if.i_vol_dec = 1'b0;
    @(negedge clk);
    bus_if.i_vol_plus = 1'b1;
    @(negedge clk);
    bus_if.i_vol_plus = 1'b0;
    chk("t4_hl_hold", hl_vec(), 4'b1000);
    repeat (2) @(negedge clk);
    chk("t4_hl_off", hl_vec(), 0);
    chk("t4_busy_off", int'(bus_if.o_busy), 0);
    repeat (3) @(negedge clk);
    frame(0, 0, 0, 0);
    #1 chk("t4_chg_count", chg_count, 8);

    // Async reset mid-HOLD with pre held through release.
    @(negedge clk);
    bus_if.i_vol_plus = 1'b1;
    @(negedge clk);
    bus_if.i_vol_plus = 1'b0;
    bus_if.i_pre = 1'b1;
    chk("t6_hl_before", hl_vec(), 4'b0010);
    #2 rst = 1'b1;
    #1 check_reset_vals("t6_async");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_hl_pre", hl_vec(), 4'b0100);
    chk("t6_chg", int'(bus_if.o_track_chg), 1);
    bus_if.i_pre = 1'b0;
    repeat (5) @(negedge clk);
    frame(3, 8, 0, 0);

    // Progress timing from a fresh reset: one step per 10 cycles, cap 3.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (19) @(negedge clk);
    frame(0, 8, 1, 1);
    repeat (8) @(negedge clk);
    frame(0, 8, 2, 1);
    repeat (69) @(negedge clk);
    frame(0, 8, 3, 1);
    bus_if.i_next = 1'b1;
    @(negedge clk);
    bus_if.i_next = 1'b0;
    frame(1, 8, 0, 1);
    repeat (8) @(negedge clk);
    frame(1, 8, 1, 1);

    repeat (4) @(negedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    chk("chg_total", chg_count, 10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
